async_bus_handshake_dst: RTL and testbench

ASYNC_BUS_HANDSHAKE_DST -- requirements
Module: async_bus_handshake_dst

---
 rtl/async_bus_handshake_dst.sv | 100 ++++++++++
 tb/tb_async_bus_handshake_dst.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_bus_handshake_dst.sv
// Destination side of a per-channel toggle (two-phase) request/acknowledge CDC handshake.
// Optional overrun detection is built only when ASYNC_BUS_HANDSHAKE_DST_OVERRUN_DET_EN is defined.
module async_bus_handshake_dst #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            src_req,
  input  logic [CHANNELS*DATA_WIDTH-1:0] src_data,
  output logic [CHANNELS-1:0]            src_ack,
  output logic [CHANNELS*DATA_WIDTH-1:0] dst_data,
  output logic [CHANNELS-1:0]            dst_src_rdy,
  input  logic [CHANNELS-1:0]            dst_dst_rdy,
  output logic [CHANNELS-1:0]            overrun,
  input  logic [CHANNELS-1:0]            overrun_clr
);

  typedef enum logic {StIdle, StHold} state_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    state_e                 state_q, state_d;
    logic                   req_event;
    logic                   violation;

    // Any level change on the synchronized request is a new transfer.
    assign req_event = sync_q[SYNC_STAGES-1] ^ prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        prev_q  <= 1'b0;
        ack_q   <= 1'b0;
        data_q  <= '0;
        state_q <= StIdle;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], src_req[ch]};
        prev_q  <= sync_q[SYNC_STAGES-1];
        ack_q   <= ack_d;
        data_q  <= data_d;
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      data_d    = data_q;
      violation = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_event) begin
            data_d  = src_data[ch*DATA_WIDTH +: DATA_WIDTH];
            state_d = StHold;
          end
        end
        StHold: begin
          if (dst_dst_rdy[ch]) begin
            state_d = StIdle;
            ack_d   = ~ack_q;
          end
          // Event is consumed without capture and without an ack toggle.
          violation = req_event;
        end
        default: state_d = StIdle;
      endcase
    end

    assign src_ack[ch]                                = ack_q;
    assign dst_data[ch*DATA_WIDTH +: DATA_WIDTH]      = data_q;
    assign dst_src_rdy[ch]                            = (state_q == StHold);

`ifdef ASYNC_BUS_HANDSHAKE_DST_OVERRUN_DET_EN
    logic overrun_q;

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        overrun_q <= 1'b0;
      end else if (violation) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr[ch]) begin
        overrun_q <= 1'b0;
      end
    end

    assign overrun[ch] = overrun_q;
`else
    logic unused_ovr;
    assign unused_ovr  = violation ^ overrun_clr[ch];
    assign overrun[ch] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_async_bus_handshake_dst.sv
// Self-checking bench for async_bus_handshake_dst: directed latency/hold/overrun/reset cases
// followed by a randomized multi-channel transfer run against a transaction-level scoreboard.
module tb_async_bus_handshake_dst;
  localparam int unsigned CH     = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned SS     = 2;
  localparam int          TARGET = 500;
`ifdef ASYNC_BUS_HANDSHAKE_DST_OVERRUN_DET_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    src_req;
  logic [CH*DW-1:0] src_data;
  logic [CH-1:0]    src_ack;
  logic [CH*DW-1:0] dst_data;
  logic [CH-1:0]    dst_src_rdy;
  logic [CH-1:0]    dst_dst_rdy;
  logic [CH-1:0]    overrun;
  logic [CH-1:0]    overrun_clr;

  int checks   = 0;
  int failures = 0;

  async_bus_handshake_dst #(
    .CHANNELS   (CH),
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_req    (src_req),
    .src_data   (src_data),
    .src_ack    (src_ack),
    .dst_data   (dst_data),
    .dst_src_rdy(dst_src_rdy),
    .dst_dst_rdy(dst_dst_rdy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] chan_data(input int chan);
    return dst_data[chan*DW +: DW];
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdy"}, dst_src_rdy, '0);
    check_eq({tag, "_ack"}, src_ack, '0);
    check_eq({tag, "_ovr"}, overrun, '0);
    for (int c = 0; c < CH; c++) check_eq({tag, "_data"}, chan_data(c), '0);
  endtask

  // Scoreboard state for the random run.
  logic [DW-1:0] exp_q [CH][$];
  logic [CH-1:0] ack_model;
  logic [CH-1:0] ack_seen;
  bit            waiting [CH];
  int            sent [CH];
  int            got [CH];

  initial begin
    logic [DW-1:0] v;
    logic          r;
    bit            done;

    rst_n       = 1'b0;
    src_req     = '0;
    src_data    = '0;
    dst_dst_rdy = '0;
    overrun_clr = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Latency: first sampling edge is the next step; rdy rises after SS edges.
    src_data[0 +: DW] = 32'hDEADBEEF;
    src_req[0]        = 1'b1;
    for (int i = 0; i < SS; i++) begin
      step();
      check_eq("lat_early", dst_src_rdy[0], 1'b0);
    end
    step();
    check_eq("lat_rdy", dst_src_rdy[0], 1'b1);
    check_eq("lat_data", chan_data(0), 32'hDEADBEEF);
    check_eq("lat_ack", src_ack[0], 1'b0);
    for (int c = 1; c < CH; c++) begin
      check_eq("lat_other_rdy", dst_src_rdy[c], 1'b0);
      check_eq("lat_other_data", chan_data(c), '0);
    end

    // Hold with consumer stalled, then accept.
    src_data[0 +: DW] = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_rdy", dst_src_rdy[0], 1'b1);
      check_eq("hold_data", chan_data(0), 32'hDEADBEEF);
      check_eq("hold_ack", src_ack[0], 1'b0);
    end
    dst_dst_rdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("acc_ack", src_ack[0], 1'b1);
      check_eq("acc_rdy", dst_src_rdy[0], 1'b0);
      check_eq("acc_data_kept", chan_data(0), 32'hDEADBEEF);
    end
    dst_dst_rdy[0] = 1'b0;

    // Second toggle on channel 2 while holding is a violation.
    src_data[2*DW +: DW] = 32'hA5A5_0002;
    src_req[2]           = 1'b1;
    repeat (SS + 1) step();
    check_eq("ovr_first_rdy", dst_src_rdy[2], 1'b1);
    src_data[2*DW +: DW] = 32'h5A5A_1234;
    src_req[2]           = 1'b0;
    repeat (SS + 2) step();
    check_eq("ovr_rdy", dst_src_rdy[2], 1'b1);
    check_eq("ovr_data", chan_data(2), 32'hA5A5_0002);
    check_eq("ovr_ack", src_ack[2], 1'b0);
    check_eq("ovr_flag", overrun[2], OVR_EN);
    check_eq("ovr_other", overrun[1:0], '0);
    step();
    check_eq("ovr_sticky", overrun[2], OVR_EN);
    overrun_clr[2] = 1'b1;
    step();
    overrun_clr[2] = 1'b0;
    check_eq("ovr_clr", overrun[2], 1'b0);
    dst_dst_rdy[2] = 1'b1;
    step();
    dst_dst_rdy[2] = 1'b0;
    check_eq("ovr_acc_ack", src_ack[2], 1'b1);
    check_eq("ovr_acc_rdy", dst_src_rdy[2], 1'b0);
    repeat (SS + 2) step();
    check_eq("ovr_consumed", dst_src_rdy[2], 1'b0);
    check_eq("ovr_no_ack", src_ack[2], 1'b1);

    // Reset in the middle of a transfer on channel 1.
    src_data[1*DW +: DW] = 32'h1111_2222;
    src_req[1]           = 1'b1;
    repeat (SS + 1) step();
    check_eq("rst_pre_rdy", dst_src_rdy[1], 1'b1);
    #2;
    rst_n   = 1'b0;
    src_req = '0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SS + 3) step();
    check_all_zero("rst_after");

    // Randomized run on all channels.
    ack_model = '0;
    ack_seen  = '0;
    for (int c = 0; c < CH; c++) begin
      waiting[c] = 1'b0;
      sent[c]    = 0;
      got[c]     = 0;
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      step();
      done = 1'b1;
      for (int c = 0; c < CH; c++) begin
        check_eq("rnd_ack", src_ack[c], ack_model[c]);
        if (src_ack[c] != ack_seen[c]) begin
          ack_seen[c] = src_ack[c];
          waiting[c]  = 1'b0;
        end
        if (!waiting[c] && sent[c] < TARGET && $urandom_range(0, 3) != 0) begin
          v                  = $urandom;
          exp_q[c].push_back(v);
          src_data[c*DW +: DW] = v;
          src_req[c]         = ~src_req[c];
          waiting[c]         = 1'b1;
          sent[c]++;
        end
        r              = 1'($urandom_range(0, 1));
        dst_dst_rdy[c] = r;
        if (dst_src_rdy[c] && r) begin
          if (exp_q[c].size() == 0) begin
            check_eq("rnd_dup_xfer", dst_src_rdy[c], 1'b0);
          end else begin
            check_eq("rnd_data", chan_data(c), exp_q[c].pop_front());
          end
          got[c]++;
          ack_model[c] = ~ack_model[c];
        end
        if (got[c] < TARGET) done = 1'b0;
      end
    end
    dst_dst_rdy = '0;
    for (int c = 0; c < CH; c++) begin
      check_eq("rnd_count", got[c], TARGET);
      check_eq("rnd_left", exp_q[c].size(), 0);
    end
    check_eq("rnd_overrun", overrun, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
